// File: rtl/reset_request_gen_pkg.sv
// Shared definitions for the reset request path: cause bit positions and
// the request FSM state encoding.
package reset_request_gen_pkg;

  localparam int CAUSE_POR = 0;
  localparam int CAUSE_BTN = 1;
  localparam int CAUSE_SW  = 2;
  localparam int CAUSE_WDT = 3;
  localparam int CAUSE_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_HOLD   = 2'd2
  } rst_state_e;

endpackage

// File: rtl/reset_request_gen_btn_debounce.sv
// Board button conditioning: two-flop synchronizer followed by a debouncer
// that accepts a new level only after DEB_CYCLES consecutive differing samples.
module btn_debounce #(
  parameter int DEB_CYCLES = 8
) (
  input  logic Clk,
  input  logic Asyncrst_n,
  input  logic Btn_n,
  output logic btn_pressed
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic [1:0]       sync_reg;
  logic             level_reg;
  logic             level_next;
  logic [CNT_W-1:0] deb_cnt_reg;
  logic [CNT_W-1:0] deb_cnt_next;

  always_ff @(posedge Clk or negedge Asyncrst_n) begin
    if (!Asyncrst_n) begin
      sync_reg    <= 2'b11;
      level_reg   <= 1'b1;
      deb_cnt_reg <= '0;
    end else begin
      sync_reg    <= {sync_reg[0], Btn_n};
      level_reg   <= level_next;
      deb_cnt_reg <= deb_cnt_next;
    end
  end

  // Any sample equal to the accepted level restarts the run of differing samples.
  always_comb begin
    level_next   = level_reg;
    deb_cnt_next = '0;
    if (sync_reg[1] != level_reg) begin
      if (deb_cnt_reg == CNT_W'(DEB_CYCLES - 1)) begin
        level_next = sync_reg[1];
      end else begin
        deb_cnt_next = deb_cnt_reg + 1'b1;
      end
    end
  end

  assign btn_pressed = ~level_reg;

endmodule

// File: rtl/reset_request_gen.sv
// Merges button, software request and watchdog into one stretched, registered
// active-low reset request, and records which sources caused it.
module reset_request_gen
  import reset_request_gen_pkg::*;
#(
  parameter int RST_CYCLES = 16,
  parameter int DEB_CYCLES = 8,
  parameter int WDT_CYCLES = 1000000
) (
  input  logic               Clk,
  input  logic               Asyncrst_n,
  input  logic               Btn_n,
  input  logic               Sw_rst,
  input  logic               Wdt_en,
  input  logic               Wdt_kick,
  input  logic               Cause_clr,
  output logic               Rst_req_n,
  output logic [CAUSE_W-1:0] Cause
);

  localparam int RST_W = $clog2(RST_CYCLES + 1);
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);

  rst_state_e         state_reg, state_next;
  logic [RST_W-1:0]   stretch_cnt_reg, stretch_cnt_next;
  logic [WDT_W-1:0]   wdt_cnt_reg, wdt_cnt_next;
  logic [CAUSE_W-1:0] cause_reg, cause_next, cause_set;
  logic               rst_req_n_reg;
  logic               btn_pressed;
  logic               wdt_counting;
  logic               wdt_expire;
  logic               trigger;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_btn_debounce (
    .Clk         (Clk),
    .Asyncrst_n  (Asyncrst_n),
    .Btn_n       (Btn_n),
    .btn_pressed (btn_pressed)
  );

  // The watchdog only runs while the core is out of reset.
  always_comb begin
    wdt_counting = Wdt_en && (state_reg == ST_IDLE) && !Wdt_kick;
    wdt_expire   = wdt_counting && (wdt_cnt_reg == WDT_W'(WDT_CYCLES - 1));
    wdt_cnt_next = (wdt_counting && !wdt_expire) ? wdt_cnt_reg + 1'b1 : '0;
    trigger      = btn_pressed | Sw_rst | wdt_expire;
  end

  always_comb begin
    state_next       = state_reg;
    stretch_cnt_next = '0;
    case (state_reg)
      ST_IDLE: begin
        if (trigger) state_next = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (stretch_cnt_reg == RST_W'(RST_CYCLES - 1)) begin
          state_next = btn_pressed ? ST_HOLD : ST_IDLE;
        end else begin
          stretch_cnt_next = stretch_cnt_reg + 1'b1;
        end
      end
      ST_HOLD: begin
        if (!btn_pressed) state_next = ST_IDLE;
      end
      default: state_next = ST_ASSERT;
    endcase
  end

  // A source asserting in the same cycle as a clear keeps its bit.
  always_comb begin
    cause_set            = '0;
    cause_set[CAUSE_BTN] = btn_pressed;
    cause_set[CAUSE_SW]  = Sw_rst;
    cause_set[CAUSE_WDT] = wdt_expire;
    cause_next           = (Cause_clr ? '0 : cause_reg) | cause_set;
  end

  always_ff @(posedge Clk or negedge Asyncrst_n) begin
    if (!Asyncrst_n) begin
      state_reg       <= ST_ASSERT;
      stretch_cnt_reg <= '0;
      wdt_cnt_reg     <= '0;
      cause_reg       <= CAUSE_W'(1) << CAUSE_POR;
      rst_req_n_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      stretch_cnt_reg <= stretch_cnt_next;
      wdt_cnt_reg     <= wdt_cnt_next;
      cause_reg       <= cause_next;
      rst_req_n_reg   <= (state_next == ST_IDLE);
    end
  end

  assign Rst_req_n = rst_req_n_reg;
  assign Cause     = cause_reg;

endmodule
